vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, framebuffer address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, framebuffer pixel width (4R/4G/4B).
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, first counterY value outside the visible area.
REQ-004 clk  in  1  25 MHz pixel clock, same clock as hvsync_generator.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 counterY  in  10  current line from hvsync_generator.
REQ-007 req0 / req1  in  1  write request from requester 0 / 1, held high until the matching ack.
REQ-008 addr0 / addr1  in  ADDR_W  write address, held stable while the request is high.
REQ-009 data0 / data1  in  DATA_W  write pixel, held stable while the request is high.
REQ-010 ack0 / ack1  out  1  one-cycle pulse; the request has been written.
REQ-011 fb_we  out  1  framebuffer write enable.
REQ-012 fb_addr  out  ADDR_W  framebuffer write address.
REQ-013 fb_data  out  DATA_W  framebuffer write data.
REQ-014 frame_tick  out  1  one-cycle pulse at the start of vertical blank.
REQ-015 wr_count  out  8  number of writes in the previous frame, saturating.

Function
REQ-016 The write window SHALL be open when counterY >= V_ACTIVE (vertical blank), subject to REQ-033.
REQ-017 The FSM SHALL have three states: IDLE, ARB and WRITE.
REQ-018 IDLE->ARB SHALL occur when the window is open and (req0|req1) is high; otherwise the FSM SHALL stay in IDLE.
REQ-019 In ARB, the winner SHALL be chosen round-robin: the sole requester wins; if both request, the requester not served last wins.
REQ-020 In ARB, the winner's addr/data SHALL be registered into fb_addr/fb_data, then ARB->WRITE.
REQ-021 ARB->IDLE with no write and no ack SHALL occur when the window has closed in that cycle or both requests are low.
REQ-022 In WRITE, fb_we=1 and the winner's ack=1 SHALL be asserted for exactly one cycle, last_served SHALL be updated, and the FSM SHALL return to IDLE unconditionally.
REQ-023 A WRITE SHALL always complete, even if the window closed in that cycle; at most one write lands on line V_ACTIVE-wrap (line 0).
REQ-024 Latency SHALL be: request seen in IDLE at cycle N, fb_we and ack at cycle N+2; sustained throughput is one write per 3 cycles.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle; fb_we SHALL equal ack0|ack1.
REQ-026 fb_addr/fb_data SHALL hold their last value outside WRITE.
REQ-027 frame_tick SHALL pulse one cycle after the cycle in which counterY changes from V_ACTIVE-1 to V_ACTIVE; this is detected with a registered previous-line compare.
REQ-028 An internal counter SHALL increment on each fb_we, saturating at 255; on frame_tick it SHALL be copied to wr_count and cleared, and a write in the same cycle SHALL count as 1 in the new frame.
REQ-029 If a requester drops req before ack, its pending transaction SHALL be discarded without a write if the FSM has not yet reached WRITE.

Reset
REQ-030 While rst_n=0 at a clk edge: FSM=IDLE, last_served=1 (requester 0 wins first tie), fb_we=0, ack0=ack1=0, fb_addr=0, fb_data=0, frame_tick=0, wr_count=0, internal counter=0, previous-line register=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no write and no ack; requesters SHALL re-request.
REQ-032 The first frame_tick after reset SHALL occur only on a real V_ACTIVE-1->V_ACTIVE transition.

Configuration
REQ-033 Macro FB_BLANK_ONLY_EN: when defined, the window SHALL follow REQ-016; when undefined, the window SHALL be always open and writes may occur during active video (tearing is accepted). frame_tick and wr_count SHALL behave identically in both builds.

Verification
REQ-034 Single request: counterY=480, req0=1, addr0=0x0A5, data0=0xFF0 -> fb_we=1, fb_addr=0x0A5, fb_data=0xFF0, and ack0 two cycles after IDLE sampling.
REQ-035 Contention: req0=req1=1 held through 4 grants in vblank -> ack order 0,1,0,1 after reset; no cycle with both acks high.
REQ-036 Blank gating (macro defined): req1=1 at counterY=100 -> no fb_we until counterY reaches 480, then ack1 is issued; with the macro undefined -> ack1 within 2 cycles at line 100.
REQ-037 Window close: request seen in IDLE at the last cycle of line 524 -> ARB sees counterY=0 -> no write, no ack; the request is served in the next vblank.
REQ-038 Frame counting: 300 writes in one frame -> wr_count=255 after the next frame_tick; 0 writes in the following frame -> wr_count=0.
REQ-039 Reset during ARB with req0=1 -> no fb_we or ack0 in that or the following cycle; all outputs are at reset values.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - two-requester round-robin framebuffer write arbiter gated to vblank
//
// Purpose:
//   Serialises pixel writes from two requesters into a single framebuffer write
//   port. Each grant takes three cycles (IDLE -> ARB -> WRITE). Also produces a
//   start-of-vblank pulse and a per-frame write count.
//
// Configuration:
//   FB_BLANK_ONLY_EN  defined   : writes are only started while counterY >= V_ACTIVE
//                     undefined : writes may start on any line (tearing accepted)
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   counterY              current line from the sync generator
//   req0/1, addr0/1,
//   data0/1               write requests, held until acknowledged
//   ack0/1                one-cycle grant-complete pulses
//   fb_we, fb_addr,
//   fb_data               framebuffer write port
//   frame_tick            one-cycle pulse at the start of vertical blank
//   wr_count              saturating write count of the previous frame
module vga_fb_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 12,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        counterY,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              frame_tick,
  output logic [7:0]        wr_count
);

  localparam logic [9:0] LP_V_ACTIVE    = 10'(V_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE_M1 = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_window;
  logic              w_any_req;
  logic              w_pick;
  logic              w_write;
  logic              r_last_served;
  logic              r_winner;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [DATA_W-1:0] r_fb_data;
  logic [9:0]        r_prev_y;
  logic              r_frame_tick;
  logic [7:0]        r_wr_count;
  logic [7:0]        r_cnt;

`ifdef FB_BLANK_ONLY_EN
  assign w_window = (counterY >= LP_V_ACTIVE);
`else
  assign w_window = 1'b1;
`endif

  assign w_any_req = req0 | req1;
  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign w_pick    = (req0 && req1) ? ~r_last_served : req1;
  assign w_write   = (r_state == S_WRITE);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_window && w_any_req) w_next = S_ARB;
      end
      S_ARB: begin
        // Requests are re-evaluated here so a dropped request or a closed window
        // abandons the grant before anything is written.
        if (w_window && w_any_req) begin
          w_load = 1'b1;
          w_next = S_WRITE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_served <= 1'b1;
      r_winner      <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_winner  <= w_pick;
        r_fb_addr <= w_pick ? addr1 : addr0;
        r_fb_data <= w_pick ? data1 : data0;
      end
      if (w_write) r_last_served <= r_winner;
    end
  end

  // Vblank start is detected from the previous line value rather than from
  // counterY alone, so holding counterY at V_ACTIVE never retriggers the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_y     <= '0;
      r_frame_tick <= 1'b0;
      r_wr_count   <= '0;
      r_cnt        <= '0;
    end else begin
      r_prev_y     <= counterY;
      r_frame_tick <= (r_prev_y == LP_V_ACTIVE_M1) && (counterY == LP_V_ACTIVE);
      if (r_frame_tick) begin
        r_wr_count <= r_cnt;
        r_cnt      <= {7'd0, w_write};
      end else if (w_write && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign fb_we      = w_write;
  assign ack0       = w_write & ~r_winner;
  assign ack1       = w_write &  r_winner;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign frame_tick = r_frame_tick;
  assign wr_count   = r_wr_count;

endmodule
